t02_reg_writeback: RTL and testbench
====================================

// Module: t02_reg_writeback
// PURPOSE
//  Write-side master for t02_register_file: owns the single write port (reg_write/write_index/write_data).
//  Merges single-cycle ALU results with in-order memory load returns; sign/zero-extends load data.
//  Keeps a scoreboard of pending load destinations and raises operand stalls for decode.
// PARAMETERS
//  DATA_W    32  register/data width
//  IDX_W     5   register index width (2**IDX_W registers)
//  LQ_DEPTH  4   max outstanding loads (power of 2, >=2)
// PORTS
//  clk             in   1       clock, all state on rising edge
//  RST             in   1       asynchronous, active-high reset
//  alu_valid       in   1       ALU result offered
//  alu_rd          in   IDX_W   ALU destination
//  alu_data        in   DATA_W  ALU result
//  alu_ready       out  1       ALU result accepted this cycle (comb)
//  ld_issue        in   1       load issued to memory
//  ld_rd           in   IDX_W   load destination
//  ld_funct3       in   3       000 LB,001 LH,010 LW,100 LBU,101 LHU
//  ld_byte_off     in   2       address[1:0] of load
//  ld_full         out  1       queue holds LQ_DEPTH entries (registered)
//  mem_ack         in   1       oldest load's data valid (one cycle per load)
//  mem_rdata       in   DATA_W  raw aligned memory word
//  rs1, rs2        in   IDX_W   decode operand indices
//  stall_rs1/2     out  1       operand not yet readable (comb)
//  rf_reg_write    out  1       to register file reg_write (registered)
//  rf_write_index  out  IDX_W   to register file write_index (registered)
//  rf_write_data   out  DATA_W  to register file write_data (registered)
//  proto_err       out  1       sticky: ack with empty queue, or issue while full without ack
// BEHAVIOUR
//  - Reset: queue empty, pending counts 0, rf_* = 0, proto_err = 0, ld_full = 0.
//  - Latency: accepted result appears on rf_* the following cycle, asserted for exactly one cycle;
//    register file holds it one edge later.
//  - Arbitration: mem_ack wins. alu_ready = !mem_ack && !(pending[alu_rd] && alu_rd!=0).
//    Not-ready ALU must hold alu_rd/alu_data; no internal ALU buffering.
//  - Load queue: FIFO of {rd, funct3, byte_off}; ld_issue pushes, mem_ack pops head.
//    Push+pop same cycle allowed when full (count unchanged). Issue while full and no ack: dropped, proto_err=1.
//    mem_ack while empty: ignored, no write, proto_err=1. Pointers wrap modulo LQ_DEPTH.
//  - Extension: byte lane = mem_rdata[8*off +: 8]; half = mem_rdata[16*off[1] +: 16];
//    LB/LH sign-extend, LBU/LHU zero-extend, LW and undefined funct3 pass word.
//  - rd==0: loads still queued/popped (consume ack) but rf_reg_write stays 0; ALU rd==0 accepted, no write.
//  - Scoreboard: per-register pending count (0..LQ_DEPTH); +1 on push, -1 on pop, net 0 if both same rd same cycle.
//  - stall_rsN = rsN!=0 && (pending[rsN]!=0 || (rf_reg_write && rf_write_index==rsN)).
//  - Reset mid-operation: all outstanding loads discarded; memory side is reset in the same domain.
// STRUCTURE
//  - t02_wb_pkg: load_type_e enum (LB,LH,LW,LBU,LHU), lq_entry_t struct, extend function.
//  - Sub-module t02_load_queue: parameterised FIFO (push/pop/full/empty/head).
//  - Top: arbitration, extension, scoreboard, output registers, error flag.
// TESTING
//  - Reset: assert RST mid-stream -> rf_*=0, ld_full=0, stall_rs*=0 next cycle, proto_err=0.
//  - ALU only: alu_valid rd=5 data=0xDEADBEEF -> alu_ready=1; next cycle rf_reg_write=1 idx=5 data=0xDEADBEEF.
//  - Extension: LB off=2, mem_rdata=0x0080FF00 -> 0xFFFFFF80; LBU same -> 0x80; LH off=2 -> 0x00000080;
//    LHU off=0 of 0x1234FFEE -> 0xFFEE.
//  - Conflict: mem_ack (rd=3) with alu_valid rd=4 -> alu_ready=0, load written first, ALU next cycle;
//    ALU rd=3 while load to x3 pending -> alu_ready=0 until ack; stall_rs1=1 for rs1=3 until writeback.
//  - Full/wrap: issue 4 loads -> ld_full=1; issue+ack same cycle keeps full; 5th issue alone -> proto_err=1;
//    drain 4 acks in order with correct rd.
//  - rd=0 / empty ack: load to x0 acked -> no write, no stall; ack with empty queue -> proto_err=1, no write.

Source files
------------

// File: rtl/t02_wb_pkg.sv
// Shared types for the register write-back block: load encodings, the per-load
// record kept in the load queue, and load data extension.
package t02_wb_pkg;

  localparam int WB_DATA_W = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_type_e;

  // Extension info per queued load; the destination index travels next to it
  // in the queue so its width can follow the top-level IDX_W parameter.
  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] byte_off;
  } lq_entry_t;

  function automatic logic [WB_DATA_W-1:0] extend(
    input logic [2:0]           funct3,
    input logic [1:0]           byteOff,
    input logic [WB_DATA_W-1:0] word
  );
    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    byteLane = word[8*byteOff +: 8];
    halfLane = word[16*byteOff[1] +: 16];
    case (funct3)
      LB:      extend = {{24{byteLane[7]}}, byteLane};
      LH:      extend = {{16{halfLane[15]}}, halfLane};
      LBU:     extend = {24'h0, byteLane};
      LHU:     extend = {16'h0, halfLane};
      default: extend = word;
    endcase
  endfunction

endpackage

// File: rtl/t02_load_queue.sv
// In-order FIFO of outstanding loads; reports which push/pop actually took
// effect so the owner can keep its scoreboard in step.
module t02_load_queue
  import t02_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             pushed_o,
  output logic             popped_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (PTR_W+1)'(DEPTH));
  assign popped_o = pop_i && !empty_o;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pushed_o = push_i && (!full_o || popped_o);
  assign head_o   = mem_q[rdPtr_q];

  always_ff @(posedge clk_i) begin
    if (pushed_o) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushed_o) wrPtr_q <= wrPtr_q + 1'b1;
      if (popped_o) rdPtr_q <= rdPtr_q + 1'b1;
      case ({pushed_o, popped_o})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/t02_reg_writeback.sv
// Sole writer of the register file: merges ALU results with in-order load
// returns, tracks pending load destinations and raises decode stalls.
module t02_reg_writeback
  import t02_wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 5,
  parameter int LQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              alu_valid,
  input  logic [IDX_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_issue,
  input  logic [IDX_W-1:0]  ld_rd,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_byte_off,
  output logic              ld_full,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [IDX_W-1:0]  rs1,
  input  logic [IDX_W-1:0]  rs2,
  output logic              stall_rs1,
  output logic              stall_rs2,
  output logic              rf_reg_write,
  output logic [IDX_W-1:0]  rf_write_index,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              proto_err
);

  localparam int NREG    = 2**IDX_W;
  localparam int CNT_W   = $clog2(LQ_DEPTH+1);
  localparam int ENTRY_W = IDX_W + $bits(lq_entry_t);

  logic [ENTRY_W-1:0] pushEntry;
  logic [ENTRY_W-1:0] headEntry;
  logic [IDX_W-1:0]   headRd;
  lq_entry_t          headInfo;
  logic               lqPushed;
  logic               lqPopped;
  logic               lqFull;
  logic               lqEmpty;
  logic               aluFire;

  logic [CNT_W-1:0]  pending_q [NREG];
  logic [NREG-1:0]   incVec;
  logic [NREG-1:0]   decVec;

  logic              rfRegWrite_q, rfRegWrite_d;
  logic [IDX_W-1:0]  rfWriteIndex_q, rfWriteIndex_d;
  logic [DATA_W-1:0] rfWriteData_q, rfWriteData_d;
  logic              protoErr_q, protoErr_d;

  assign pushEntry          = {ld_rd, ld_funct3, ld_byte_off};
  assign {headRd, headInfo} = headEntry;

  t02_load_queue #(
    .DEPTH (LQ_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_load_queue (
    .clk_i    (clk),
    .rst_i    (RST),
    .push_i   (ld_issue),
    .pop_i    (mem_ack),
    .data_i   (pushEntry),
    .pushed_o (lqPushed),
    .popped_o (lqPopped),
    .full_o   (lqFull),
    .empty_o  (lqEmpty),
    .head_o   (headEntry)
  );

  assign ld_full = lqFull;

  // Memory owns the write port whenever it acks; an ALU result targeting a
  // register with a load still in flight would be overwritten out of order.
  assign alu_ready = !mem_ack && !((pending_q[alu_rd] != '0) && (alu_rd != '0));
  assign aluFire   = alu_valid && alu_ready;

  always_comb begin
    rfRegWrite_d   = 1'b0;
    rfWriteIndex_d = alu_rd;
    rfWriteData_d  = alu_data;
    if (lqPopped) begin
      rfRegWrite_d   = (headRd != '0);
      rfWriteIndex_d = headRd;
      rfWriteData_d  = extend(headInfo.funct3, headInfo.byte_off, mem_rdata);
    end else if (aluFire) begin
      rfRegWrite_d   = (alu_rd != '0);
    end
  end

  assign protoErr_d = protoErr_q || (mem_ack && lqEmpty) || (ld_issue && lqFull && !mem_ack);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rfRegWrite_q   <= 1'b0;
      rfWriteIndex_q <= '0;
      rfWriteData_q  <= '0;
      protoErr_q     <= 1'b0;
    end else begin
      rfRegWrite_q   <= rfRegWrite_d;
      rfWriteIndex_q <= rfWriteIndex_d;
      rfWriteData_q  <= rfWriteData_d;
      protoErr_q     <= protoErr_d;
    end
  end

  always_comb begin
    incVec = '0;
    decVec = '0;
    if (lqPushed) incVec[ld_rd]  = 1'b1;
    if (lqPopped) decVec[headRd] = 1'b1;
  end

  // A push and pop to the same register in one cycle leave its count alone.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) pending_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (incVec[i] && !decVec[i]) begin
          pending_q[i] <= pending_q[i] + CNT_W'(1);
        end else if (!incVec[i] && decVec[i]) begin
          pending_q[i] <= pending_q[i] - CNT_W'(1);
        end
      end
    end
  end

  assign stall_rs1 = (rs1 != '0) &&
                     ((pending_q[rs1] != '0) || (rfRegWrite_q && (rfWriteIndex_q == rs1)));
  assign stall_rs2 = (rs2 != '0) &&
                     ((pending_q[rs2] != '0) || (rfRegWrite_q && (rfWriteIndex_q == rs2)));

  assign rf_reg_write   = rfRegWrite_q;
  assign rf_write_index = rfWriteIndex_q;
  assign rf_write_data  = rfWriteData_q;
  assign proto_err      = protoErr_q;

endmodule

// File: tb/tb_t02_reg_writeback.sv
// Scenario bench for t02_reg_writeback: expected register-file writes are
// queued as stimulus is driven and popped as the DUT writes.
module tb_t02_reg_writeback;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        RST;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_byte_off;
  logic        ld_full;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall_rs1;
  logic        stall_rs2;
  logic        rf_reg_write;
  logic [4:0]  rf_write_index;
  logic [31:0] rf_write_data;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  wr_t        expWr[$];
  logic [4:0] issued[$];

  t02_reg_writeback dut (
    .clk            (clk),
    .RST            (RST),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .ld_issue       (ld_issue),
    .ld_rd          (ld_rd),
    .ld_funct3      (ld_funct3),
    .ld_byte_off    (ld_byte_off),
    .ld_full        (ld_full),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .rs1            (rs1),
    .rs2            (rs2),
    .stall_rs1      (stall_rs1),
    .stall_rs2      (stall_rs2),
    .rf_reg_write   (rf_reg_write),
    .rf_write_index (rf_write_index),
    .rf_write_data  (rf_write_data),
    .proto_err      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every register-file write must match the oldest expected write.
  always begin : monitor
    wr_t w;
    @(posedge clk);
    #1;
    if (!RST && rf_reg_write) begin
      total++;
      if (expWr.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_write: got idx=%0d data=%h, required no write", rf_write_index, rf_write_data);
      end else begin
        w = expWr.pop_front();
        if (rf_write_index !== w.idx || rf_write_data !== w.data) begin
          bad++;
          $display("[TB] FAIL write_value: got idx=%0d data=%h, required idx=%0d data=%h",
                   rf_write_index, rf_write_data, w.idx, w.data);
        end
      end
    end
  end

  task automatic idle;
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    ld_issue    = 1'b0;
    ld_rd       = '0;
    ld_funct3   = 3'b010;
    ld_byte_off = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    rs1         = '0;
    rs2         = '0;
  endtask

  task automatic test_reset;
    rs1 = 5'd3;
    rs2 = 5'd4;
    @(posedge clk);
    #1;
    total++;
    if (rf_reg_write !== 1'b0 || rf_write_index !== 5'd0 || rf_write_data !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_rf: got we=%b idx=%0d data=%h, required 0/0/0", rf_reg_write, rf_write_index, rf_write_data);
    end
    total++;
    if (ld_full !== 1'b0 || proto_err !== 1'b0 || stall_rs1 !== 1'b0 || stall_rs2 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got full=%b err=%b st1=%b st2=%b, required all 0", ld_full, proto_err, stall_rs1, stall_rs2);
    end
    @(negedge clk);
    RST = 1'b0;
    idle();
  endtask

  task automatic test_alu_only;
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; rs1 = 5'd5;
    #1;
    total++;
    if (alu_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL alu_ready_free: got %b, required 1", alu_ready);
    end
    if (alu_ready === 1'b1) expWr.push_back('{5'd5, 32'hDEADBEEF});
    @(negedge clk);
    total++;
    if (rf_reg_write !== 1'b1 || rf_write_index !== 5'd5) begin
      bad++;
      $display("[TB] FAIL alu_latency: got we=%b idx=%0d, required we=1 idx=5", rf_reg_write, rf_write_index);
    end
    total++;
    if (stall_rs1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stall_inflight_write: got %b, required 1", stall_rs1);
    end
    alu_rd = 5'd0; alu_data = 32'h00001234;
    #1;
    total++;
    if (alu_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL alu_ready_x0: got %b, required 1", alu_ready);
    end
    @(negedge clk);
    alu_valid = 1'b0;
    total++;
    if (rf_reg_write !== 1'b0) begin
      bad++;
      $display("[TB] FAIL alu_x0_no_write: got we=%b, required 0", rf_reg_write);
    end
    total++;
    if (stall_rs1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_clear_after_write: got %b, required 0", stall_rs1);
    end
  endtask

  task automatic test_extension;
    logic [2:0]  f3s  [9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b000, 3'b000, 3'b011};
    logic [1:0]  offs [9] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3, 2'd1, 2'd0};
    logic [31:0] words[9] = '{32'h0080FF00, 32'h0080FF00, 32'h0080FF00, 32'h1234FFEE, 32'h89ABCDEF,
                              32'h1234FFEE, 32'h7F000000, 32'h0000A500, 32'hCAFEF00D};
    logic [31:0] exps [9] = '{32'hFFFFFF80, 32'h00000080, 32'h00000080, 32'h0000FFEE, 32'h89ABCDEF,
                              32'hFFFFFFEE, 32'h0000007F, 32'hFFFFFFA5, 32'hCAFEF00D};
    logic [4:0]  rd;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ld_issue = 1'b1; ld_rd = 5'(10 + i); ld_funct3 = f3s[i]; ld_byte_off = offs[i];
      rs1 = 5'(10 + i);
      issued.push_back(5'(10 + i));
      @(negedge clk);
      ld_issue = 1'b0;
      total++;
      if (stall_rs1 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stall_pending_load%0d: got %b, required 1", i, stall_rs1);
      end
      mem_ack = 1'b1; mem_rdata = words[i];
      rd = issued.pop_front();
      expWr.push_back('{rd, exps[i]});
      @(negedge clk);
      mem_ack = 1'b0;
    end
    idle();
  endtask

  task automatic test_conflict;
    logic [4:0] rd;
    @(negedge clk);
    ld_issue = 1'b1; ld_rd = 5'd3; ld_funct3 = 3'b010; ld_byte_off = 2'd0;
    issued.push_back(5'd3);
    @(negedge clk);
    ld_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33; rs1 = 5'd3;
    #1;
    total++;
    if (alu_ready !== 1'b0 || stall_rs1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL alu_blocked_pending: got ready=%b stall=%b, required 0/1", alu_ready, stall_rs1);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    alu_rd = 5'd4; alu_data = 32'h44;
    rd = issued.pop_front();
    expWr.push_back('{rd, 32'h11112222});
    #1;
    total++;
    if (alu_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL alu_blocked_by_ack: got %b, required 0", alu_ready);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    total++;
    if (rf_reg_write !== 1'b1 || rf_write_index !== 5'd3) begin
      bad++;
      $display("[TB] FAIL load_written_first: got we=%b idx=%0d, required 1/3", rf_reg_write, rf_write_index);
    end
    #1;
    total++;
    if (alu_ready !== 1'b1 || stall_rs1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL alu_after_ack: got ready=%b stall=%b, required 1/1", alu_ready, stall_rs1);
    end
    if (alu_ready === 1'b1) expWr.push_back('{5'd4, 32'h44});
    @(negedge clk);
    alu_rd = 5'd3; alu_data = 32'h33;
    #1;
    total++;
    if (alu_ready !== 1'b1 || stall_rs1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL x3_free_after_writeback: got ready=%b stall=%b, required 1/0", alu_ready, stall_rs1);
    end
    if (alu_ready === 1'b1) expWr.push_back('{5'd3, 32'h33});
    @(negedge clk);
    alu_valid = 1'b0;
    ld_issue = 1'b1; ld_rd = 5'd6;
    issued.push_back(5'd6);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h66;
    issued.push_back(5'd6);
    rd = issued.pop_front();
    expWr.push_back('{rd, 32'h66});
    @(negedge clk);
    ld_issue = 1'b0; mem_ack = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h600; rs2 = 5'd6;
    #1;
    total++;
    if (alu_ready !== 1'b0 || stall_rs2 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pending_net_zero: got ready=%b stall=%b, required 0/1", alu_ready, stall_rs2);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h67;
    rd = issued.pop_front();
    expWr.push_back('{rd, 32'h67});
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    total++;
    if (alu_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL alu_x6_after_drain: got %b, required 1", alu_ready);
    end
    if (alu_ready === 1'b1) expWr.push_back('{5'd6, 32'h600});
    @(negedge clk);
    idle();
  endtask

  task automatic test_full_wrap;
    logic [4:0] rd;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ld_issue = 1'b1; ld_rd = 5'(20 + k); ld_funct3 = 3'b010;
      issued.push_back(5'(20 + k));
    end
    @(negedge clk);
    total++;
    if (ld_full !== 1'b1) begin
      bad++;
      $display("[TB] FAIL full_after_four: got %b, required 1", ld_full);
    end
    ld_rd = 5'd24; mem_ack = 1'b1; mem_rdata = 32'hA0;
    rd = issued.pop_front();
    expWr.push_back('{rd, 32'hA0});
    issued.push_back(5'd24);
    @(negedge clk);
    total++;
    if (ld_full !== 1'b1 || proto_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_kept_push_pop: got full=%b err=%b, required 1/0", ld_full, proto_err);
    end
    ld_rd = 5'd25; mem_ack = 1'b0;
    @(negedge clk);
    ld_issue = 1'b0;
    total++;
    if (proto_err !== 1'b1 || ld_full !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drop_when_full: got err=%b full=%b, required 1/1", proto_err, ld_full);
    end
    rs2 = 5'd25;
    #1;
    total++;
    if (stall_rs2 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL dropped_not_pending: got %b, required 0", stall_rs2);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'hB0 + 32'(k);
      rd = issued.pop_front();
      expWr.push_back('{rd, 32'hB0 + 32'(k)});
    end
    @(negedge clk);
    mem_ack = 1'b0;
    total++;
    if (ld_full !== 1'b0) begin
      bad++;
      $display("[TB] FAIL not_full_after_drain: got %b, required 0", ld_full);
    end
    idle();
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    ld_issue = 1'b1; ld_rd = 5'd7; ld_funct3 = 3'b010;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    issued.push_back(5'd7);
    #1;
    if (alu_ready === 1'b1) expWr.push_back('{5'd9, 32'h99});
    @(negedge clk);
    ld_rd = 5'd8; alu_valid = 1'b0;
    issued.push_back(5'd8);
    @(negedge clk);
    ld_issue = 1'b0; rs1 = 5'd7; rs2 = 5'd8;
    #1;
    total++;
    if (stall_rs1 !== 1'b1 || stall_rs2 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stall_before_reset: got %b/%b, required 1/1", stall_rs1, stall_rs2);
    end
    RST = 1'b1;
    issued.delete();
    #1;
    total++;
    if (rf_reg_write !== 1'b0 || rf_write_index !== 5'd0 || rf_write_data !== 32'd0) begin
      bad++;
      $display("[TB] FAIL midreset_rf: got we=%b idx=%0d data=%h, required 0/0/0", rf_reg_write, rf_write_index, rf_write_data);
    end
    total++;
    if (ld_full !== 1'b0 || proto_err !== 1'b0 || stall_rs1 !== 1'b0 || stall_rs2 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_flags: got full=%b err=%b st1=%b st2=%b, required all 0", ld_full, proto_err, stall_rs1, stall_rs2);
    end
    @(negedge clk);
    RST = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    #1;
    total++;
    if (alu_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_after_reset: got %b, required 1", alu_ready);
    end
    if (alu_ready === 1'b1) expWr.push_back('{5'd7, 32'h77});
    @(negedge clk);
    idle();
  endtask

  task automatic test_rd0_empty_ack;
    @(negedge clk);
    ld_issue = 1'b1; ld_rd = 5'd0; ld_funct3 = 3'b010;
    issued.push_back(5'd0);
    @(negedge clk);
    ld_issue = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5;
    void'(issued.pop_front());
    #1;
    total++;
    if (stall_rs1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL x0_no_stall: got %b, required 0", stall_rs1);
    end
    @(negedge clk);
    total++;
    if (rf_reg_write !== 1'b0 || proto_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL x0_ack_consumed: got we=%b err=%b, required 0/0", rf_reg_write, proto_err);
    end
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
    #1;
    total++;
    if (alu_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ready_during_empty_ack: got %b, required 0", alu_ready);
    end
    @(negedge clk);
    mem_ack = 1'b0; alu_valid = 1'b0;
    total++;
    if (rf_reg_write !== 1'b0 || proto_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL empty_ack: got we=%b err=%b, required 0/1", rf_reg_write, proto_err);
    end
    repeat (2) @(negedge clk);
    total++;
    if (proto_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL proto_err_sticky: got %b, required 1", proto_err);
    end
    total++;
    if (expWr.size() != 0) begin
      bad++;
      $display("[TB] FAIL missing_writes: got %0d outstanding, required 0", expWr.size());
    end
  endtask

  initial begin
    idle();
    RST = 1'b1;
    test_reset();
    test_alu_only();
    test_extension();
    test_conflict();
    test_full_wrap();
    test_reset_mid();
    test_rd0_empty_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
